// File: rtl/iram_fetch_if.sv
// iram_fetch_if: program-load and fetch bus between loader/control unit and instruction memory
interface iram_fetch_if #(
  parameter int INSTR_W = 20,
  parameter int ADDR_W  = 7
);
  logic               load_start;
  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_done;
  logic               load_ready;
  logic               load_full;
  logic               run_start;
  logic               halt;
  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_pc;
  logic               stall;
  logic               fetch_valid;
  logic [INSTR_W-1:0] instr_out;
  logic               addr_err;
  logic [ADDR_W:0]    prog_len;
  logic [1:0]         state;
  modport master (
    output load_start, load_valid, load_data, load_done, run_start, halt, fetch_req, fetch_pc, stall,
    input  load_ready, load_full, fetch_valid, instr_out, addr_err, prog_len, state
  );
  modport slave (
    input  load_start, load_valid, load_data, load_done, run_start, halt, fetch_req, fetch_pc, stall,
    output load_ready, load_full, fetch_valid, instr_out, addr_err, prog_len, state
  );
endinterface

// File: rtl/iram_fetch.sv
// iram_fetch: run-time loadable instruction memory with registered, stallable fetch port
module iram_fetch #(
  parameter int                 INSTR_W  = 20,
  parameter int                 ADDR_W   = 7,
  parameter int                 DEPTH    = 128,
  parameter logic [INSTR_W-1:0] NOP_WORD = {4'b1110, 16'b0}
) (
  input logic          clk,
  input logic          rst,
  iram_fetch_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  state_t             st;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]    len;
  logic               ready, full, fvalid, aerr;
  logic [INSTR_W-1:0] instr;
  logic               wr, in_range;
  assign wr       = st == LOAD && bus.load_valid && ready;
  assign in_range = {1'b0, bus.fetch_pc} < len;
  always_ff @(posedge clk)
    if (wr) mem[len[AW-1:0]] <= bus.load_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      len    <= '0;
      ready  <= 1'b0;
      full   <= 1'b0;
      fvalid <= 1'b0;
      instr  <= '0;
      aerr   <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (bus.load_start) begin
            st    <= LOAD;
            len   <= '0;
            full  <= 1'b0;
            ready <= 1'b1;
          end else if (bus.run_start) st <= RUN;
        end
        LOAD: begin
          if (wr) len <= len + 1'b1;
          // the DEPTH-th accepted word ends the load on the same edge
          if (wr && len + 1'b1 == DEPTH_L) begin
            full  <= 1'b1;
            ready <= 1'b0;
            st    <= IDLE;
          end else if (bus.load_done) begin
            ready <= 1'b0;
            st    <= IDLE;
          end
        end
        RUN: begin
          if (bus.halt) begin
            fvalid <= 1'b0;
            st     <= IDLE;
          end else if (!bus.stall) begin
            fvalid <= bus.fetch_req;
            if (bus.fetch_req) begin
              instr <= in_range ? mem[bus.fetch_pc[AW-1:0]] : NOP_WORD;
              aerr  <= !in_range;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
  assign bus.state       = st;
  assign bus.prog_len    = len;
  assign bus.load_ready  = ready;
  assign bus.load_full   = full;
  assign bus.fetch_valid = fvalid;
  assign bus.instr_out   = instr;
  assign bus.addr_err    = aerr;
endmodule

// File: tb/tb_iram_fetch.sv
// tb_iram_fetch: directed checks of load, fetch, stall/halt, range and full behaviour
module tb_iram_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  iram_fetch_if #(.INSTR_W(20), .ADDR_W(7)) m ();
  iram_fetch_if #(.INSTR_W(20), .ADDR_W(7)) s ();
  iram_fetch #(.DEPTH(128)) dut (.clk(clk), .rst(rst), .bus(m.slave));
  iram_fetch #(.DEPTH(4))   dut4 (.clk(clk), .rst(rst), .bus(s.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [6:0] pc, input logic [19:0] exp_i, input logic exp_e, input string tag);
    m.fetch_req = 1'b1;
    m.fetch_pc  = pc;
    step();
    chk({tag, ".valid"}, 32'(m.fetch_valid), 32'd1);
    chk({tag, ".instr"}, 32'(m.instr_out), 32'(exp_i));
    chk({tag, ".err"}, 32'(m.addr_err), 32'(exp_e));
  endtask
  initial begin
    {m.load_start, m.load_valid, m.load_data, m.load_done, m.run_start, m.halt, m.fetch_req, m.fetch_pc, m.stall} = '0;
    {s.load_start, s.load_valid, s.load_data, s.load_done, s.run_start, s.halt, s.fetch_req, s.fetch_pc, s.stall} = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst.state", 32'(m.state), 32'd0);
    chk("rst.len", 32'(m.prog_len), 32'd0);
    chk("rst.valid", 32'(m.fetch_valid), 32'd0);
    chk("rst.instr", 32'(m.instr_out), 32'd0);
    chk("rst.err", 32'(m.addr_err), 32'd0);
    chk("rst.full", 32'(m.load_full), 32'd0);
    m.load_start = 1'b1;
    step();
    m.load_start = 1'b0;
    chk("load.state", 32'(m.state), 32'd1);
    chk("load.ready", 32'(m.load_ready), 32'd1);
    m.load_valid = 1'b1;
    m.load_data = 20'h30001; step();
    m.load_data = 20'h34002; step();
    m.load_data = 20'h38003; step();
    m.load_valid = 1'b0;
    m.load_done = 1'b1;
    step();
    m.load_done = 1'b0;
    chk("done.state", 32'(m.state), 32'd0);
    chk("done.len", 32'(m.prog_len), 32'd3);
    chk("done.ready", 32'(m.load_ready), 32'd0);
    m.run_start = 1'b1;
    step();
    m.run_start = 1'b0;
    chk("run.state", 32'(m.state), 32'd2);
    fetch(7'd0, 20'h30001, 1'b0, "f0");
    fetch(7'd1, 20'h34002, 1'b0, "f1");
    fetch(7'd2, 20'h38003, 1'b0, "f2");
    fetch(7'd3, 20'hE0000, 1'b1, "oor3");
    fetch(7'd127, 20'hE0000, 1'b1, "oor127");
    m.fetch_req = 1'b0;
    step();
    chk("idle.valid", 32'(m.fetch_valid), 32'd0);
    chk("idle.hold", 32'(m.instr_out), 32'hE0000);
    chk("idle.err", 32'(m.addr_err), 32'd1);
    fetch(7'd1, 20'h34002, 1'b0, "pre_stall");
    m.stall = 1'b1;
    m.fetch_pc = 7'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.valid", 32'(m.fetch_valid), 32'd1);
      chk("stall.instr", 32'(m.instr_out), 32'h34002);
    end
    m.stall = 1'b0;
    fetch(7'd2, 20'h38003, 1'b0, "unstall");
    m.stall = 1'b1;
    m.halt = 1'b1;
    step();
    {m.stall, m.halt, m.fetch_req} = '0;
    chk("halt.state", 32'(m.state), 32'd0);
    chk("halt.valid", 32'(m.fetch_valid), 32'd0);
    m.load_start = 1'b1;
    m.run_start = 1'b1;
    step();
    {m.load_start, m.run_start} = '0;
    chk("prio.state", 32'(m.state), 32'd1);
    chk("prio.len", 32'(m.prog_len), 32'd0);
    m.load_valid = 1'b1;
    m.load_data = 20'h11111; step();
    m.load_data = 20'h22222; step();
    m.load_valid = 1'b0;
    chk("mid.len", 32'(m.prog_len), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid.state", 32'(m.state), 32'd0);
    chk("mid.len0", 32'(m.prog_len), 32'd0);
    m.run_start = 1'b1;
    step();
    m.run_start = 1'b0;
    fetch(7'd0, 20'hE0000, 1'b1, "postrst");
    m.fetch_req = 1'b0;
    s.load_start = 1'b1;
    step();
    s.load_start = 1'b0;
    s.load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s.load_data = 20'hA0000 + 20'(i);
      step();
    end
    chk("full.flag", 32'(s.load_full), 32'd1);
    chk("full.state", 32'(s.state), 32'd0);
    chk("full.len", 32'(s.prog_len), 32'd4);
    chk("full.ready", 32'(s.load_ready), 32'd0);
    s.load_data = 20'hBBBBB;
    step();
    s.load_valid = 1'b0;
    chk("extra.len", 32'(s.prog_len), 32'd4);
    chk("extra.state", 32'(s.state), 32'd0);
    s.run_start = 1'b1;
    step();
    s.run_start = 1'b0;
    s.fetch_req = 1'b1;
    s.fetch_pc = 7'd3;
    step();
    chk("d4.last", 32'(s.instr_out), 32'hA0003);
    chk("d4.last_err", 32'(s.addr_err), 32'd0);
    s.fetch_pc = 7'd4;
    step();
    chk("d4.oor", 32'(s.instr_out), 32'hE0000);
    chk("d4.oor_err", 32'(s.addr_err), 32'd1);
    s.fetch_req = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
